// File: rtl/aes_load_ctrl.sv
// Load sequencer for the AES-128 core: fetches key and plaintext bytes from a
// byte-wide synchronous RAM, kicks the core and registers the ciphertext.
module aes_load_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int KEY_BASE = 0,
  parameter int PT_BASE  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              reuse_key,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_rdata,
  output logic [127:0]      key_in,
  output logic [127:0]      plain_in,
  output logic              aes_start,
  input  logic              aes_done,
  input  logic [127:0]      aes_cipher,
  output logic [127:0]      cipher_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, FETCH, FLUSH, KICK, WAIT, DONE} state_t;

  state_t            state, state_next;
  logic [4:0]        idx, idx_next, cap_idx;
  logic              cap_en, key_valid;
  logic              rd_next, start_next, done_next;
  logic [ADDR_W-1:0] addr_next;

  // Indices 0..15 address the key, 16..31 the plaintext; the sum wraps mod 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [4:0] k);
    int base;
    base = k[4] ? PT_BASE : KEY_BASE;
    return ADDR_W'(base + int'(k[3:0]));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: if (start) begin
        state_next = FETCH;
        idx_next   = (reuse_key && key_valid) ? 5'd16 : 5'd0;
      end
      FETCH: begin
        if (idx == 5'd31) state_next = FLUSH;
        else              idx_next   = idx + 5'd1;
      end
      FLUSH:   state_next = KICK;
      KICK:    state_next = WAIT;
      WAIT:    if (aes_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are precomputed from the next state so their registers line up with it.
  always_comb begin
    rd_next    = (state_next == FETCH);
    addr_next  = rd_next ? addr_of(idx_next) : '0;
    start_next = (state_next == KICK);
    done_next  = (state_next == DONE);
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      ram_rd     <= 1'b0;
      ram_addr   <= '0;
      aes_start  <= 1'b0;
      done       <= 1'b0;
      cap_en     <= 1'b0;
      cap_idx    <= '0;
      key_valid  <= 1'b0;
      key_in     <= '0;
      plain_in   <= '0;
      cipher_out <= '0;
    end else begin
      idx       <= idx_next;
      ram_rd    <= rd_next;
      ram_addr  <= addr_next;
      aes_start <= start_next;
      done      <= done_next;
      // RAM data trails the read by one cycle, so the issued index is delayed alongside it.
      cap_en    <= ram_rd;
      cap_idx   <= idx;
      if (cap_en) begin
        if (cap_idx[4]) plain_in[{cap_idx[3:0], 3'b000} +: 8] <= ram_rdata;
        else            key_in[{cap_idx[3:0], 3'b000} +: 8]   <= ram_rdata;
      end
      if (state == KICK) key_valid <= 1'b1;
      if (state == WAIT && aes_done) cipher_out <= aes_cipher;
    end
  end

endmodule

// File: tb/tb_aes_load_ctrl.sv
// Randomized self-checking bench for aes_load_ctrl against a cycle-level job model,
// plus a second instance exercising address wrap-around of the key region.
module tb_aes_load_ctrl;

  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              start, reuse_key, ram_rd, aes_start, aes_done, busy, done;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_rdata;
  logic [127:0]      key_in, plain_in, aes_cipher, cipher_out;

  logic              start_w, ram_rd_w, aes_start_w, aes_done_w, busy_w, done_w;
  logic [ADDR_W-1:0] ram_addr_w;
  logic [7:0]        ram_rdata_w;
  logic [127:0]      key_in_w, plain_in_w, aes_cipher_w, cipher_out_w;

  logic [7:0] mem [0:31];

  aes_load_ctrl #(.ADDR_W(ADDR_W), .KEY_BASE(0), .PT_BASE(16)) dut (
    .clk(clk), .rst(rst), .start(start), .reuse_key(reuse_key),
    .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .key_in(key_in), .plain_in(plain_in), .aes_start(aes_start),
    .aes_done(aes_done), .aes_cipher(aes_cipher), .cipher_out(cipher_out),
    .busy(busy), .done(done)
  );

  aes_load_ctrl #(.ADDR_W(ADDR_W), .KEY_BASE(28), .PT_BASE(12)) dut_w (
    .clk(clk), .rst(rst), .start(start_w), .reuse_key(1'b0),
    .ram_rd(ram_rd_w), .ram_addr(ram_addr_w), .ram_rdata(ram_rdata_w),
    .key_in(key_in_w), .plain_in(plain_in_w), .aes_start(aes_start_w),
    .aes_done(aes_done_w), .aes_cipher(aes_cipher_w), .cipher_out(cipher_out_w),
    .busy(busy_w), .done(done_w)
  );

  // Synchronous RAM: data appears one cycle after the read.
  always @(posedge clk) begin
    if (ram_rd)   ram_rdata   <= mem[ram_addr];
    if (ram_rd_w) ram_rdata_w <= mem[ram_addr_w];
  end

  int total = 0;
  int bad = 0;

  bit           mdl_key_valid;
  logic [127:0] mdl_key, mdl_cipher;

  task checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int addr_of(int k, int kb, int pb);
    return ((k < 16) ? kb + k : pb + k - 16) % 32;
  endfunction

  task tick();
    @(posedge clk);
    #1;
  endtask

  // One job starting in the current IDLE cycle (cycle 0); returns in the first IDLE cycle after DONE.
  task applyStimulus(input bit reuse, input bit hold_start, input bit glitch, input int delay);
    bit full;
    int first, nreads, kick, fin;
    logic [127:0] ek, ep, ec;
    full   = !(reuse && mdl_key_valid);
    first  = full ? 0 : 16;
    nreads = 32 - first;
    kick   = nreads + 2;
    fin    = kick + delay + 1;
    for (int i = 0; i < 16; i++) begin
      ek[8*i +: 8] = mem[addr_of(i, 0, 16)];
      ep[8*i +: 8] = mem[addr_of(16 + i, 0, 16)];
    end
    if (!full) ek = mdl_key;
    ec = {4{32'hdeadbeef}} ^ {$urandom, $urandom, $urandom, $urandom};
    start     = 1'b1;
    reuse_key = reuse;
    for (int c = 1; c <= fin + 1; c++) begin
      tick();
      if (!hold_start || c == fin) start = 1'b0;
      reuse_key = 1'($urandom_range(0, 1));
      checkOutput("ram_rd", 128'(ram_rd), 128'(c <= nreads));
      if (ram_rd && c <= nreads)
        checkOutput("ram_addr", 128'(ram_addr), 128'(addr_of(first + c - 1, 0, 16)));
      checkOutput("aes_start", 128'(aes_start), 128'(c == kick));
      checkOutput("done", 128'(done), 128'(c == fin));
      checkOutput("busy", 128'(busy), 128'(c <= fin));
      if (c == fin) checkOutput("cipher_out", cipher_out, ec);
      if (glitch && c == 6) checkOutput("cipher_glitch", cipher_out, mdl_cipher);
      aes_done   = (c == kick + delay) || (glitch && c == 5);
      aes_cipher = (c == kick + delay) ? ec : ~ec;
    end
    aes_done = 1'b0;
    checkOutput("key_in", key_in, ek);
    checkOutput("plain_in", plain_in, ep);
    mdl_key_valid = 1'b1;
    mdl_key       = ek;
    mdl_cipher    = ec;
  endtask

  task resetMidFetch();
    start     = 1'b1;
    reuse_key = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      tick();
      start = 1'b0;
    end
    checkOutput("addr_idx20", 128'(ram_addr), 128'(addr_of(20, 0, 16)));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_busy", 128'(busy), 128'd0);
    checkOutput("rst_ram_rd", 128'(ram_rd), 128'd0);
    checkOutput("rst_ram_addr", 128'(ram_addr), 128'd0);
    checkOutput("rst_key_in", key_in, 128'd0);
    checkOutput("rst_plain_in", plain_in, 128'd0);
    checkOutput("rst_cipher", cipher_out, 128'd0);
    for (int c = 0; c < 40; c++) begin
      aes_done   = (c % 7 == 3);
      aes_cipher = {$urandom, $urandom, $urandom, $urandom};
      tick();
      checkOutput("abort_aes_start", 128'(aes_start), 128'd0);
      checkOutput("abort_done", 128'(done), 128'd0);
      checkOutput("abort_busy", 128'(busy), 128'd0);
    end
    aes_done = 1'b0;
    checkOutput("abort_cipher", cipher_out, 128'd0);
    mdl_key_valid = 1'b0;
    mdl_key       = '0;
    mdl_cipher    = '0;
  endtask

  task runWrapJob();
    logic [127:0] ek, ep, ec;
    for (int i = 0; i < 16; i++) begin
      ek[8*i +: 8] = mem[addr_of(i, 28, 12)];
      ep[8*i +: 8] = mem[addr_of(16 + i, 28, 12)];
    end
    ec = {$urandom, $urandom, $urandom, $urandom};
    start_w = 1'b1;
    for (int c = 1; c <= 39; c++) begin
      tick();
      start_w = 1'b0;
      checkOutput("w_ram_rd", 128'(ram_rd_w), 128'(c <= 32));
      if (ram_rd_w && c <= 32)
        checkOutput("w_ram_addr", 128'(ram_addr_w), 128'(addr_of(c - 1, 28, 12)));
      checkOutput("w_aes_start", 128'(aes_start_w), 128'(c == 34));
      checkOutput("w_done", 128'(done_w), 128'(c == 38));
      aes_done_w   = (c == 37);
      aes_cipher_w = ec;
    end
    aes_done_w = 1'b0;
    checkOutput("w_key_in", key_in_w, ek);
    checkOutput("w_plain_in", plain_in_w, ep);
    checkOutput("w_cipher", cipher_out_w, ec);
    checkOutput("w_busy", 128'(busy_w), 128'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; reuse_key = 1'b0; aes_done = 1'b0; aes_cipher = '0;
    start_w = 1'b0; aes_done_w = 1'b0; aes_cipher_w = '0;
    mdl_key_valid = 1'b0; mdl_key = '0; mdl_cipher = '0;
    for (int i = 0; i < 16; i++) begin
      mem[i]      = 8'(i + 1);
      mem[16 + i] = 8'(8'hf1 + i);
    end
    tick();
    tick();
    checkOutput("reset_busy", 128'(busy), 128'd0);
    checkOutput("reset_ram_rd", 128'(ram_rd), 128'd0);
    checkOutput("reset_ram_addr", 128'(ram_addr), 128'd0);
    checkOutput("reset_key_in", key_in, 128'd0);
    checkOutput("reset_cipher", cipher_out, 128'd0);
    checkOutput("reset_done", 128'(done), 128'd0);
    rst = 1'b0;
    tick();

    applyStimulus(1'b0, 1'b0, 1'b0, 10);
    checkOutput("key_const", key_in, 128'h100f0e0d0c0b0a090807060504030201);
    checkOutput("plain_const", plain_in, 128'h00fffefdfcfbfaf9f8f7f6f5f4f3f2f1);

    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    applyStimulus(1'b1, 1'b0, 1'b0, $urandom_range(1, 12));
    checkOutput("reuse_key_kept", key_in, 128'h100f0e0d0c0b0a090807060504030201);

    applyStimulus(1'b0, 1'b1, 1'b1, $urandom_range(1, 12));

    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(1, 12));
    end

    resetMidFetch();
    applyStimulus(1'b1, 1'b0, 1'b0, 5);

    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    runWrapJob();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
